// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi decoder traceback stage (K=7, 64 states).
// Holds code constants, the traceback FSM state type, and the layout of one
// 7-bit survivor entry {d, seg[3:0], idx[1:0]} as delivered by the ACS unit.
package viterbi_pkg;

  localparam int K               = 7;
  localparam int NUM_STATES      = 64;
  localparam int NUM_SEGS        = 16;
  localparam int ENTRIES_PER_SEG = 4;
  localparam int ENTRY_W         = 7;
  localparam int TAIL            = K - 1;

  localparam int STATE_W = 6;
  localparam int SEG_W   = 4;
  localparam int IDX_W   = 2;
  localparam int SURV_W  = ENTRIES_PER_SEG * ENTRY_W;

  // Field offsets inside one survivor entry
  localparam int ENT_D_POS   = 6;
  localparam int ENT_SEG_LSB = 2;
  localparam int ENT_IDX_LSB = 0;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_TRACE = 2'd1,
    ST_EMIT  = 2'd2
  } tb_state_e;

  typedef struct packed {
    logic             d;
    logic [SEG_W-1:0] seg;
    logic [IDX_W-1:0] idx;
  } surv_entry_t;

  function automatic surv_entry_t unpack_entry(input logic [ENTRY_W-1:0] raw);
    surv_entry_t e;
    e.d   = raw[ENT_D_POS];
    e.seg = raw[ENT_SEG_LSB +: SEG_W];
    e.idx = raw[ENT_IDX_LSB +: IDX_W];
    return e;
  endfunction

endpackage

// File: rtl/viterbi_traceback_survivor_ram.sv
// Decision memory: DEPTH rows of 64 decision bits (one per trellis state).
// Ports: clk; wr_en/wr_addr/wr_data commit a whole row; rd_addr selects a row
// and rd_bit selects the state whose decision bit appears on rd_d
// (combinational read, so traceback can consume one row per cycle).
module survivor_ram
  import viterbi_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [NUM_STATES-1:0]      wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  input  logic [STATE_W-1:0]         rd_bit,
  output logic                       rd_d
);

  logic [NUM_STATES-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_d = mem[rd_addr][rd_bit];

endmodule

// File: rtl/viterbi_traceback.sv
// Survivor collection and traceback for the K=7 Viterbi decoder.
// Ports:
//   Clock, Reset      - clock, synchronous active-high reset
//   SurvValid         - Survivors holds one ACS segment (four entries)
//   Survivors[27:0]   - four {d, seg, idx} entries, MSB entry first
//   FrameEnd          - with accepted segment 15: last trellis step of frame
//   Hold              - busy, upstream must stall
//   DecodedBit/Valid/Last - decoded bit stream in forward order
//   Error             - sticky protocol error
// Frames are buffered row by row, traced back from state 0 one row per
// cycle, then the non-tail bits are streamed out one per cycle.
module viterbi_traceback
  import viterbi_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              SurvValid,
  input  logic [SURV_W-1:0] Survivors,
  input  logic              FrameEnd,
  output logic              Hold,
  output logic              DecodedBit,
  output logic              DecodedValid,
  output logic              DecodedLast,
  output logic              Error
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] DEPTH_P  = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] TAIL_P   = PTR_W'(TAIL);
  localparam logic [PTR_W-1:0] ONE_P    = PTR_W'(1);
  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(NUM_SEGS - 1);

  tb_state_e             state_q, state_d;
  logic [SEG_W-1:0]      exp_seg_q, exp_seg_d;
  logic [NUM_STATES-1:0] staging_q, staging_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      nrows_q, nrows_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         emit_idx_q, emit_idx_d;
  logic [STATE_W-1:0]    tstate_q, tstate_d;
  logic [DEPTH-1:0]      obuf_q, obuf_d;
  logic                  hold_q, hold_d;
  logic                  bit_q, bit_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  error_q, error_d;

  logic                  ram_we;
  logic [NUM_STATES-1:0] ram_wdata;
  logic                  ram_d;
  logic [PTR_W-1:0]      frame_rows;
  logic [AW-1:0]         emit_last;
  logic                  seg_ok;
  surv_entry_t           ent [ENTRIES_PER_SEG];

  genvar gi;
  for (gi = 0; gi < ENTRIES_PER_SEG; gi++) begin : g_ent
    assign ent[gi] = unpack_entry(Survivors[SURV_W-1-gi*ENTRY_W -: ENTRY_W]);
  end

  // A segment is in order only if every entry carries the expected index
  always_comb begin
    seg_ok = 1'b1;
    for (int e = 0; e < ENTRIES_PER_SEG; e++) begin
      if (ent[e].seg != exp_seg_q) begin
        seg_ok = 1'b0;
      end
    end
  end

  // An overflowed frame keeps exactly DEPTH rows
  assign frame_rows = (wr_ptr_q == DEPTH_P) ? DEPTH_P : wr_ptr_q + ONE_P;
  assign emit_last  = AW'(nrows_q - TAIL_P - ONE_P);

  survivor_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (Clock),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (ram_wdata),
    .rd_addr (rd_ptr_q),
    .rd_bit  (tstate_q),
    .rd_d    (ram_d)
  );

  always_comb begin
    state_d    = state_q;
    exp_seg_d  = exp_seg_q;
    staging_d  = staging_q;
    wr_ptr_d   = wr_ptr_q;
    nrows_d    = nrows_q;
    rd_ptr_d   = rd_ptr_q;
    emit_idx_d = emit_idx_q;
    tstate_d   = tstate_q;
    obuf_d     = obuf_q;
    error_d    = error_q;
    bit_d      = 1'b0;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    ram_we     = 1'b0;
    ram_wdata  = staging_q;

    case (state_q)
      ST_FILL: begin
        if (SurvValid) begin
          if (seg_ok) begin
            for (int e = 0; e < ENTRIES_PER_SEG; e++) begin
              staging_d[{ent[e].seg, ent[e].idx}] = ent[e].d;
            end
            // Row written includes this cycle's entries
            ram_wdata = staging_d;
            if (exp_seg_q == SEG_LAST) begin
              exp_seg_d = '0;
              if (wr_ptr_q == DEPTH_P) begin
                error_d = 1'b1;
              end else begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + ONE_P;
              end
              if (FrameEnd) begin
                state_d  = ST_TRACE;
                nrows_d  = frame_rows;
                rd_ptr_d = AW'(frame_rows - ONE_P);
                tstate_d = '0;
                wr_ptr_d = '0;
              end
            end else begin
              exp_seg_d = exp_seg_q + SEG_W'(1);
            end
          end else begin
            error_d   = 1'b1;
            exp_seg_d = '0;
          end
        end
      end

      ST_TRACE: begin
        if (SurvValid) begin
          error_d = 1'b1;
        end
        obuf_d[rd_ptr_q] = tstate_q[STATE_W-1];
        tstate_d = {tstate_q[STATE_W-2:0], ram_d};
        if (rd_ptr_q == '0) begin
          // Frames no longer than the tail have nothing to emit
          state_d    = (nrows_q > TAIL_P) ? ST_EMIT : ST_FILL;
          emit_idx_d = '0;
        end else begin
          rd_ptr_d = rd_ptr_q - AW'(1);
        end
      end

      ST_EMIT: begin
        if (SurvValid) begin
          error_d = 1'b1;
        end
        valid_d = 1'b1;
        bit_d   = obuf_q[emit_idx_q];
        if (emit_idx_q == emit_last) begin
          last_d  = 1'b1;
          state_d = ST_FILL;
        end else begin
          emit_idx_d = emit_idx_q + AW'(1);
        end
      end

      default: state_d = ST_FILL;
    endcase

    hold_d = (state_d != ST_FILL);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_FILL;
      exp_seg_q  <= '0;
      staging_q  <= '0;
      wr_ptr_q   <= '0;
      nrows_q    <= '0;
      rd_ptr_q   <= '0;
      emit_idx_q <= '0;
      tstate_q   <= '0;
      hold_q     <= 1'b0;
      bit_q      <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_seg_q  <= exp_seg_d;
      staging_q  <= staging_d;
      wr_ptr_q   <= wr_ptr_d;
      nrows_q    <= nrows_d;
      rd_ptr_q   <= rd_ptr_d;
      emit_idx_q <= emit_idx_d;
      tstate_q   <= tstate_d;
      hold_q     <= hold_d;
      bit_q      <= bit_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      error_q    <= error_d;
    end
  end

  // Output buffer contents are don't-care after reset
  always_ff @(posedge Clock) begin
    obuf_q <= obuf_d;
  end

  assign Hold         = hold_q;
  assign DecodedBit   = bit_q;
  assign DecodedValid = valid_q;
  assign DecodedLast  = last_q;
  assign Error        = error_q;

endmodule
